// File: rtl/ex_stage_if.sv
// Operation encodings and the ID/EX -> EX/MEM bundle for ex_stage.
// master drives the instruction side, slave is the execute stage.
package ex_pkg;
    localparam logic [7:0] op_null = 8'h00;
    localparam logic [7:0] op_add  = 8'h01;
    localparam logic [7:0] op_sub  = 8'h02;
    localparam logic [7:0] op_and  = 8'h03;
    localparam logic [7:0] op_or   = 8'h04;
    localparam logic [7:0] op_xor  = 8'h05;
    localparam logic [7:0] op_sll  = 8'h06;
    localparam logic [7:0] op_srl  = 8'h07;
    localparam logic [7:0] op_sra  = 8'h08;
    localparam logic [7:0] op_slt  = 8'h09;
    localparam logic [7:0] op_sltu = 8'h0a;
    localparam logic [7:0] op_div  = 8'h0b;
    localparam logic [7:0] op_divu = 8'h0c;
    localparam logic [7:0] op_rem  = 8'h0d;
    localparam logic [7:0] op_remu = 8'h0e;

    localparam logic [2:0] type_null  = 3'd0;
    localparam logic [2:0] type_logic = 3'd1;
    localparam logic [2:0] type_shift = 3'd2;
    localparam logic [2:0] type_arith = 3'd3;
    localparam logic [2:0] type_div   = 3'd4;
endpackage

interface ex_stage_if #(
    parameter int OP_W   = 8,
    parameter int TYPE_W = 3
);
    logic              flush;
    logic [OP_W-1:0]   op_i;
    logic [TYPE_W-1:0] type_i;
    logic [31:0]       reg1_i;
    logic [31:0]       reg2_i;
    logic              we_i;
    logic [4:0]        waddr_i;
    logic              we_o;
    logic [4:0]        waddr_o;
    logic [31:0]       wdata_o;
    logic              stall_req;

    modport master (
        output flush, op_i, type_i,
        output reg1_i, reg2_i,
        output we_i, waddr_i,
        input  we_o, waddr_o,
        input  wdata_o, stall_req
    );

    modport slave (
        input  flush, op_i, type_i,
        input  reg1_i, reg2_i,
        input  we_i, waddr_i,
        output we_o, waddr_o,
        output wdata_o, stall_req
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU plus iterative 32-step divider.
// Divider present only when EX_DIV_EN is defined.
module ex_stage
    import ex_pkg::*;
#(
    parameter int OP_W   = 8,
    parameter int TYPE_W = 3,
    parameter int XLEN   = 32
) (
    input logic      clk,
    input logic      rst,
    ex_stage_if.slave bus
);

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      shamt;
    logic            ty_ok;

    assign a     = bus.reg1_i;
    assign b     = bus.reg2_i;
    assign shamt = bus.reg2_i[4:0];
    assign ty_ok = bus.type_i != TYPE_W'(type_null);

    logic is_add, is_sub, is_and, is_or, is_xor;
    logic is_sll, is_srl, is_sra, is_slt, is_sltu;
    logic is_div, is_divu, is_rem, is_remu;
    logic div_op;

    assign is_add  = bus.op_i == OP_W'(op_add);
    assign is_sub  = bus.op_i == OP_W'(op_sub);
    assign is_and  = bus.op_i == OP_W'(op_and);
    assign is_or   = bus.op_i == OP_W'(op_or);
    assign is_xor  = bus.op_i == OP_W'(op_xor);
    assign is_sll  = bus.op_i == OP_W'(op_sll);
    assign is_srl  = bus.op_i == OP_W'(op_srl);
    assign is_sra  = bus.op_i == OP_W'(op_sra);
    assign is_slt  = bus.op_i == OP_W'(op_slt);
    assign is_sltu = bus.op_i == OP_W'(op_sltu);
    assign is_div  = bus.op_i == OP_W'(op_div);
    assign is_divu = bus.op_i == OP_W'(op_divu);
    assign is_rem  = bus.op_i == OP_W'(op_rem);
    assign is_remu = bus.op_i == OP_W'(op_remu);

    assign div_op = (bus.type_i == TYPE_W'(type_div))
                  & (is_div | is_divu | is_rem | is_remu);

    logic [XLEN-1:0] alu_res;
    logic            alu_ok;

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b0;
        if (ty_ok) begin
            alu_ok = 1'b1;
            unique case (1'b1)
                is_add:  alu_res = a + b;
                is_sub:  alu_res = a - b;
                is_and:  alu_res = a & b;
                is_or:   alu_res = a | b;
                is_xor:  alu_res = a ^ b;
                is_sll:  alu_res = a << shamt;
                is_srl:  alu_res = a >> shamt;
                is_sra:  alu_res = $signed(a) >>> shamt;
                is_slt:  alu_res = {{(XLEN-1){1'b0}},
                                    $signed(a) < $signed(b)};
                is_sltu: alu_res = {{(XLEN-1){1'b0}}, a < b};
                default: alu_ok  = 1'b0;
            endcase
        end
    end

    logic            stall;
    logic            done;
    logic [XLEN-1:0] div_res;

`ifdef EX_DIV_EN
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_st_t;

    div_st_t st, st_nxt;

    logic [XLEN-1:0] dvd, dsr, quo, rem;
    logic [CW-1:0]   cnt;
    logic            neg_q, neg_r;
    logic            sgn;
    logic            b_zero;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] q_out, r_out;

    assign sgn    = is_div | is_rem;
    assign b_zero = b == '0;
    assign abs_a  = (sgn && a[XLEN-1]) ? -a : a;
    assign abs_b  = (sgn && b[XLEN-1]) ? -b : b;
    assign trial  = {rem, dvd[XLEN-1]} - {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (rst)
            st <= S_IDLE;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        unique case (st)
            S_IDLE:
                if (!bus.flush && div_op)
                    st_nxt = b_zero ? S_DONE : S_BUSY;
            S_BUSY:
                if (bus.flush)
                    st_nxt = S_IDLE;
                else if (cnt == CW'(XLEN-1))
                    st_nxt = S_DONE;
            S_DONE:
                st_nxt = S_IDLE;
            default:
                st_nxt = S_IDLE;
        endcase
    end

    // Divide by zero preloads the RISC-V result so DONE needs no special case.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd   <= '0;
            dsr   <= '0;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (st == S_IDLE && st_nxt != S_IDLE) begin
            dvd   <= abs_a;
            dsr   <= abs_b;
            quo   <= b_zero ? '1 : '0;
            rem   <= b_zero ? abs_a : '0;
            cnt   <= '0;
            neg_q <= sgn & (a[XLEN-1] ^ b[XLEN-1]) & ~b_zero;
            neg_r <= sgn & a[XLEN-1];
        end else if (st == S_BUSY && !bus.flush) begin
            dvd <= {dvd[XLEN-2:0], 1'b0};
            cnt <= cnt + 1'b1;
            if (!trial[XLEN]) begin
                rem <= trial[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
                rem <= {rem[XLEN-2:0], dvd[XLEN-1]};
                quo <= {quo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign q_out   = neg_q ? -quo : quo;
    assign r_out   = neg_r ? -rem : rem;
    assign div_res = (is_rem | is_remu) ? r_out : q_out;
    assign done    = st == S_DONE;
    assign stall   = (st == S_IDLE && div_op)
                   || st == S_BUSY;
`else
    logic unused_div;

    assign unused_div = clk ^ div_op ^ is_divu ^ is_remu;
    assign div_res    = '0;
    assign done       = 1'b0;
    assign stall      = 1'b0;
`endif

    always_comb begin
        bus.stall_req = 1'b0;
        bus.we_o      = 1'b0;
        bus.wdata_o   = '0;
        bus.waddr_o   = rst ? 5'd0 : bus.waddr_i;
        if (!rst && !bus.flush) begin
            bus.stall_req = stall;
            if (done) begin
                bus.we_o    = bus.we_i;
                bus.wdata_o = div_res;
            end else if (!stall && alu_ok) begin
                bus.we_o    = bus.we_i;
                bus.wdata_o = alu_res;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, divider latency,
// divide boundaries, flush and reset.
module tb_ex_stage;
    import ex_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    ex_stage_if #(.OP_W(8), .TYPE_W(3)) bus ();

    ex_stage #(.OP_W(8), .TYPE_W(3), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op,
                         input logic [2:0] ty,
                         input logic [31:0] r1,
                         input logic [31:0] r2,
                         input logic [4:0] wa);
        bus.op_i    = op;
        bus.type_i  = ty;
        bus.reg1_i  = r1;
        bus.reg2_i  = r2;
        bus.we_i    = 1'b1;
        bus.waddr_i = wa;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input string tag,
                       input logic [7:0] op,
                       input logic [2:0] ty,
                       input logic [31:0] r1,
                       input logic [31:0] r2,
                       input logic [31:0] exp);
        next_cyc();
        drive(op, ty, r1, r2, 5'd7);
        @(negedge clk);
        chk(tag, bus.wdata_o, exp);
        chk({tag, "_we"}, {31'd0, bus.we_o}, 32'd1);
        chk({tag, "_stall"}, {31'd0, bus.stall_req}, 32'd0);
    endtask

`ifdef EX_DIV_EN
    task automatic div_run(input string tag,
                           input logic [7:0] op,
                           input logic [31:0] r1,
                           input logic [31:0] r2,
                           input int lat,
                           input logic [31:0] exp);
        int n;
        next_cyc();
        drive(op, type_div, r1, r2, 5'd9);
        n = 0;
        @(negedge clk);
        chk({tag, "_we0"}, {31'd0, bus.we_o}, 32'd0);
        while (bus.stall_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, n, lat);
        chk(tag, bus.wdata_o, exp);
        chk({tag, "_we"}, {31'd0, bus.we_o}, 32'd1);
        next_cyc();
        drive(op_null, type_null, 32'd0, 32'd0, 5'd0);
    endtask
`endif

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.flush = 1'b0;
        drive(op_add, type_arith, 32'd1, 32'd2, 5'd3);

        @(negedge clk);
        chk("rst_wdata", bus.wdata_o, 32'd0);
        chk("rst_we", {31'd0, bus.we_o}, 32'd0);
        chk("rst_waddr", {27'd0, bus.waddr_o}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
        next_cyc();
        rst = 1'b0;

        alu("add_wrap", op_add, type_arith,
            32'h7FFFFFFF, 32'd1, 32'h80000000);
        chk("waddr", {27'd0, bus.waddr_o}, 32'd7);
        alu("sub", op_sub, type_arith,
            32'd5, 32'd7, 32'hFFFFFFFE);
        alu("and", op_and, type_logic,
            32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        alu("or", op_or, type_logic,
            32'hF000_0001, 32'h0000_0010, 32'hF000_0011);
        alu("xor", op_xor, type_logic,
            32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        alu("sll", op_sll, type_shift,
            32'h0000_0003, 32'h0000_0024, 32'h0000_0030);
        alu("srl", op_srl, type_shift,
            32'hF000_0000, 32'd4, 32'h0F00_0000);
        alu("sra", op_sra, type_shift,
            32'hF000_0000, 32'd4, 32'hFF00_0000);
        alu("slt", op_slt, type_arith,
            32'hFFFFFFFF, 32'd1, 32'd1);
        alu("sltu", op_sltu, type_arith,
            32'hFFFFFFFF, 32'd1, 32'd0);

        next_cyc();
        drive(op_null, type_null, 32'd5, 32'd6, 5'd2);
        @(negedge clk);
        chk("null_wdata", bus.wdata_o, 32'd0);
        chk("null_we", {31'd0, bus.we_o}, 32'd0);

`ifdef EX_DIV_EN
        div_run("div_neg", op_div, 32'hFFFFFFF9, 32'd2,
                33, 32'hFFFFFFFD);
        div_run("rem_neg", op_rem, 32'hFFFFFFF9, 32'd2,
                33, 32'hFFFFFFFF);
        div_run("divu", op_divu, 32'd1000, 32'd7,
                33, 32'd142);
        div_run("remu", op_remu, 32'd1000, 32'd7,
                33, 32'd6);
        div_run("divu_z", op_divu, 32'd100, 32'd0,
                1, 32'hFFFFFFFF);
        div_run("remu_z", op_remu, 32'd100, 32'd0,
                1, 32'd100);
        div_run("div_ovf", op_div, 32'h80000000, 32'hFFFFFFFF,
                33, 32'h80000000);
        div_run("rem_ovf", op_rem, 32'h80000000, 32'hFFFFFFFF,
                33, 32'd0);

        next_cyc();
        drive(op_divu, type_div, 32'd1000, 32'd7, 5'd4);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", {31'd0, bus.stall_req}, 32'd0);
        chk("flush_we", {31'd0, bus.we_o}, 32'd0);
        next_cyc();
        bus.flush = 1'b0;
        drive(op_add, type_arith, 32'd3, 32'd4, 5'd4);
        @(negedge clk);
        chk("flush_idle", {31'd0, bus.stall_req}, 32'd0);
        chk("flush_add", bus.wdata_o, 32'd7);

        next_cyc();
        drive(op_div, type_div, 32'hFFFFFF9C, 32'd3, 5'd6);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_stall", {31'd0, bus.stall_req}, 32'd0);
        chk("mrst_we", {31'd0, bus.we_o}, 32'd0);
        chk("mrst_wdata", bus.wdata_o, 32'd0);
        chk("mrst_waddr", {27'd0, bus.waddr_o}, 32'd0);
        next_cyc();
        rst = 1'b0;
        drive(op_add, type_arith, 32'd10, 32'd20, 5'd6);
        @(negedge clk);
        chk("mrst_idle", {31'd0, bus.stall_req}, 32'd0);
        chk("mrst_add", bus.wdata_o, 32'd30);
        chk("mrst_addwe", {31'd0, bus.we_o}, 32'd1);
`else
        next_cyc();
        drive(op_div, type_div, 32'hFFFFFFF9, 32'd2, 5'd5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nodiv_stall", {31'd0, bus.stall_req}, 32'd0);
            chk("nodiv_we", {31'd0, bus.we_o}, 32'd0);
            chk("nodiv_wdata", bus.wdata_o, 32'd0);
        end
        alu("nodiv_add", op_add, type_arith,
            32'd10, 32'd20, 32'd30);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
